// File: rtl/float_mult_arbiter.sv
// float_mult_arbiter: shares one pipelined FP multiplier among N_REQ requesters.
// Operand submissions are granted round-robin, and the winner's index is queued
// in an in-order tag FIFO. Each multiplier result is routed back to its issuer
// one cycle after it returns.
module float_mult_arbiter #(
   parameter int FLEN         = 64,
   parameter int N_REQ        = 4,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_vld,
   input  logic [N_REQ*FLEN-1:0]   req_a,
   input  logic [N_REQ*FLEN-1:0]   req_b,
   output logic [N_REQ-1:0]        req_rdy,
   output logic [N_REQ-1:0]        rsp_vld,
   output logic [FLEN-1:0]         rsp_res,
   output logic                    rsp_err,
   output logic                    mul_vld,
   output logic [FLEN-1:0]         mul_a,
   output logic [FLEN-1:0]         mul_b,
   input  logic                    mul_res_vld,
   input  logic [FLEN-1:0]         mul_res,
   input  logic                    mul_err,
   output logic                    busy,
   output logic                    spurious
);

   localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   // state registers
   logic [TW-1:0]    ptr_q, ptr_d;
   logic [TW-1:0]    tag_q [MAX_INFLIGHT];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [FLEN-1:0]  rsp_res_q, rsp_res_d;
   logic             rsp_err_q, rsp_err_d;
   logic             busy_q, busy_d;
   logic             spurious_q, spurious_d;

   // combinational helpers
   logic [TW-1:0]    winner_s;
   logic             found_s;
   logic             issue_s;
   logic             pop_s;

   // Round-robin search: first valid requester at or after ptr, wrapping.
   always_comb begin
      winner_s = '0;
      found_s  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found_s && req_vld[(int'(ptr_q) + k) % N_REQ]) begin
            found_s  = 1'b1;
            winner_s = TW'((int'(ptr_q) + k) % N_REQ);
         end
      end
   end

   // Issue/handshake decode and multiplier-side operand mux. The full check
   // uses the registered count, so a pop never frees a slot in the same cycle.
   always_comb begin
      issue_s = found_s && (cnt_q < CW'(MAX_INFLIGHT));
      pop_s   = mul_res_vld && (cnt_q != '0);
      if (issue_s) begin
         req_rdy = ONE_HOT0 << winner_s;
         mul_vld = 1'b1;
         mul_a   = req_a[int'(winner_s)*FLEN +: FLEN];
         mul_b   = req_b[int'(winner_s)*FLEN +: FLEN];
      end else begin
         req_rdy = '0;
         mul_vld = 1'b0;
         mul_a   = '0;
         mul_b   = '0;
      end
   end

   // Next-state for pointer, FIFO indices, inflight count and response outputs.
   always_comb begin
      ptr_d      = ptr_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      rsp_vld_d  = '0;
      rsp_res_d  = rsp_res_q;
      rsp_err_d  = rsp_err_q;
      spurious_d = spurious_q;

      if (issue_s) begin
         ptr_d = (winner_s == TW'(N_REQ - 1)) ? '0 : winner_s + TW'(1);
         wr_d  = (wr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_q + PW'(1);
      end else begin
         ptr_d = ptr_q;
         wr_d  = wr_q;
      end

      if (pop_s) begin
         rd_d      = (rd_q == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_q + PW'(1);
         rsp_vld_d = ONE_HOT0 << tag_q[rd_q];
         rsp_res_d = mul_res;
         rsp_err_d = mul_err;
      end else if (mul_res_vld) begin
         // Result with no outstanding tag: flag it, route nothing.
         spurious_d = 1'b1;
      end else begin
         rd_d = rd_q;
      end

      case ({issue_s, pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      busy_d = (cnt_d != '0);
   end

   // State update with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         rsp_vld_q  <= '0;
         rsp_res_q  <= '0;
         rsp_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         spurious_q <= 1'b0;
         for (int i = 0; i < MAX_INFLIGHT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_res_q  <= rsp_res_d;
         rsp_err_q  <= rsp_err_d;
         busy_q     <= busy_d;
         spurious_q <= spurious_d;
         if (issue_s) begin
            tag_q[wr_q] <= winner_s;
         end
      end
   end

   assign rsp_vld  = rsp_vld_q;
   assign rsp_res  = rsp_res_q;
   assign rsp_err  = rsp_err_q;
   assign busy     = busy_q;
   assign spurious = spurious_q;

endmodule

// File: tb/tb_float_mult_arbiter.sv
// Testbench for float_mult_arbiter: directed scenarios followed by a random
// phase, all compared against a queue-based reference model. The bench also
// plays the multiplier, returning products in issue order.
module tb_float_mult_arbiter;

   localparam int FLEN = 64;
   localparam int N    = 4;
   localparam int MAXI = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_vld;
   logic [N*FLEN-1:0] req_a, req_b;
   logic [N-1:0]      req_rdy, rsp_vld;
   logic [FLEN-1:0]   rsp_res, mul_a, mul_b, mul_res;
   logic              rsp_err, mul_vld, mul_res_vld, mul_err, busy, spurious;

   always #5 clk = ~clk;

   float_mult_arbiter #(.FLEN(FLEN), .N_REQ(N), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
      .rsp_vld(rsp_vld), .rsp_res(rsp_res), .rsp_err(rsp_err),
      .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b),
      .mul_res_vld(mul_res_vld), .mul_res(mul_res), .mul_err(mul_err),
      .busy(busy), .spurious(spurious)
   );

   int errors = 0;
   int checks = 0;

   // reference model state
   int              ptr_m;
   int              tagq[$];
   logic [64:0]     mulq[$];   // {err, result} pending in the multiplier
   logic [N-1:0]    exp_rsp_vld;
   logic [63:0]     exp_res;
   logic            exp_err, exp_busy, exp_spur;
   logic [N-1:0]    obs_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [64:0] fmul(input logic [63:0] a, input logic [63:0] b);
      logic e;
      e = (a[62:52] == 11'h7FF) || (b[62:52] == 11'h7FF);
      return {e, $realtobits($bitstoreal(a) * $bitstoreal(b))};
   endfunction

   task automatic chk_regs();
      chk("rsp_vld",  64'(rsp_vld),  64'(exp_rsp_vld));
      chk("rsp_res",  rsp_res,       exp_res);
      chk("rsp_err",  64'(rsp_err),  64'(exp_err));
      chk("busy",     64'(busy),     64'(exp_busy));
      chk("spurious", 64'(spurious), 64'(exp_spur));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      req_vld = '0;
      mul_res_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      ptr_m = 0;
      tagq.delete();
      mulq.delete();
      exp_rsp_vld = '0;
      exp_res = 64'h0;
      exp_err = 1'b0;
      exp_busy = 1'b0;
      exp_spur = 1'b0;
      chk_regs();
      rst = 1'b0;
   endtask

   // One clock: optionally return a multiplier result, check the
   // combinational grant, then advance the model and check registered outputs.
   task automatic cycle(input bit ret);
      logic [64:0]  r;
      logic [N-1:0] exp_rdy;
      logic [63:0]  ga, gb, rres;
      logic         rerr;
      int           g, t;
      if (ret) begin
         if (mulq.size() > 0) r = mulq.pop_front();
         else                 r = {1'b0, $urandom, $urandom};
         mul_res_vld = 1'b1;
         mul_err = r[64];
         mul_res = r[63:0];
      end else begin
         mul_res_vld = 1'b0;
         mul_err = 1'($urandom);
         mul_res = {$urandom, $urandom};
      end
      #1;
      g = (tagq.size() < MAXI) ? rr_pick(req_vld, ptr_m) : -1;
      exp_rdy = (g >= 0) ? (N'(1) << g) : N'(0);
      ga = (g >= 0) ? req_a[g*FLEN +: FLEN] : 64'h0;
      gb = (g >= 0) ? req_b[g*FLEN +: FLEN] : 64'h0;
      rres = mul_res;
      rerr = mul_err;
      obs_rdy = req_rdy;
      chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      chk("mul_vld", 64'(mul_vld), 64'(g >= 0));
      chk("mul_a", mul_a, ga);
      chk("mul_b", mul_b, gb);
      @(posedge clk);
      #1;
      exp_rsp_vld = '0;
      if (ret) begin
         if (tagq.size() > 0) begin
            t = tagq.pop_front();
            exp_rsp_vld = N'(1) << t;
            exp_res = rres;
            exp_err = rerr;
         end else begin
            exp_spur = 1'b1;
         end
      end
      if (g >= 0) begin
         tagq.push_back(g);
         mulq.push_back(fmul(ga, gb));
         ptr_m = (g + 1) % N;
         req_vld[g] = 1'b0;
      end
      exp_busy = (tagq.size() != 0);
      chk_regs();
   endtask

   initial begin
      rst = 1'b1;
      req_vld = '0;
      req_a = '0;
      req_b = '0;
      mul_res_vld = 1'b0;
      mul_res = 64'h0;
      mul_err = 1'b0;
      do_reset(2);

      // single op: 2.0 * 3.0 from requester 0
      req_a[0 +: FLEN] = 64'h4000000000000000;
      req_b[0 +: FLEN] = 64'h4008000000000000;
      req_vld = 4'b0001;
      cycle(1'b0);
      chk("single_rdy", 64'(obs_rdy), 64'h1);
      chk("single_busy", 64'(busy), 64'h1);
      cycle(1'b1);
      chk("single_rsp_vld", 64'(rsp_vld), 64'h1);
      chk("single_res", rsp_res, 64'h4018000000000000);
      cycle(1'b0);
      chk("single_idle", 64'(busy), 64'h0);

      // round-robin from reset, then full FIFO
      do_reset(1);
      for (int i = 0; i < N; i++) begin
         req_a[i*FLEN +: FLEN] = {$urandom, $urandom};
         req_b[i*FLEN +: FLEN] = {$urandom, $urandom};
      end
      req_vld = 4'b1111;
      for (int i = 0; i < N; i++) begin
         cycle(1'b0);
         chk("rr_grant", 64'(obs_rdy), 64'(4'b0001 << i));
      end
      req_vld[0] = 1'b1;
      cycle(1'b1);
      chk("full_blocked", 64'(obs_rdy), 64'h0);
      chk("rr_rsp0", 64'(rsp_vld), 64'h1);
      cycle(1'b0);
      chk("full_reopen", 64'(obs_rdy), 64'h1);
      for (int i = 1; i < N; i++) begin
         cycle(1'b1);
         chk("rr_rsp", 64'(rsp_vld), 64'(4'b0001 << i));
      end
      cycle(1'b1);

      // fairness after wrap: ptr reaches 3 via a grant to 2
      req_vld = 4'b0100;
      cycle(1'b0);
      req_vld = 4'b1010;
      cycle(1'b0);
      chk("fair_first", 64'(obs_rdy), 64'h8);
      cycle(1'b0);
      chk("fair_second", 64'(obs_rdy), 64'h2);
      repeat (3) cycle(1'b1);

      // error routing: Inf * 1.0 from requester 2
      req_a[2*FLEN +: FLEN] = 64'h7FF0000000000000;
      req_b[2*FLEN +: FLEN] = 64'h3FF0000000000000;
      req_vld = 4'b0100;
      cycle(1'b0);
      cycle(1'b1);
      chk("err_rsp_vld", 64'(rsp_vld), 64'h4);
      chk("err_flag", 64'(rsp_err), 64'h1);
      chk("err_res", rsp_res, 64'h7FF0000000000000);

      // spurious result while idle, then reset clears it
      cycle(1'b1);
      chk("spur_set", 64'(spurious), 64'h1);
      chk("spur_no_rsp", 64'(rsp_vld), 64'h0);
      do_reset(1);
      chk("spur_cleared", 64'(spurious), 64'h0);

      // random traffic, with a mid-operation reset
      for (int c = 0; c < 400; c++) begin
         if (c == 200) do_reset(1);
         for (int i = 0; i < N; i++) begin
            if (!req_vld[i] && $urandom_range(0, 2) == 0) begin
               req_a[i*FLEN +: FLEN] = {$urandom, $urandom};
               req_b[i*FLEN +: FLEN] = {$urandom, $urandom};
               req_vld[i] = 1'b1;
            end else if (req_vld[i] && $urandom_range(0, 15) == 0) begin
               req_vld[i] = 1'b0;
            end
         end
         cycle(mulq.size() > 0 && $urandom_range(0, 1) == 1);
      end
      req_vld = '0;
      for (int c = 0; c < MAXI + 1; c++) begin
         if (mulq.size() > 0) cycle(1'b1);
      end
      cycle(1'b0);
      chk("final_idle", 64'(busy), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
